ft_tx_scheduler: RTL and testbench
==================================

Name: ft_tx_scheduler

Overview:
- Schedules the FT600 write (FPGA-to-host) stream between two sources:
  - IQ sample FIFO: AFE RX samples, 24-bit pairs.
  - CPU message FIFO: ECPU replies, 32-bit words.
- Emits framed packets, each a header word followed by payload, on a valid/ready stream toward the FT600 write path.
- Sits between the a2f/cpuout FIFOs and the FT600 FSM.
- Round-robin arbitration at packet granularity.

Parameters:
- FT_DATA_WIDTH, 32, output word width (fixed 32 for header layout)
- IQ_PAIR_WIDTH, 24, IQ FIFO word width; I = [11:0], Q = [23:12]
- QSTART_BIT_INDEX, 16, bit position of Q LSB in output payload word
- PKT_WORDS, 32, IQ payload words per packet (1..255)
- CPU_BURST, 8, maximum CPU payload words per packet (1..255)
- LVL_W, 8, width of CPU FIFO level input

Ports:
- clk  in  1  single clock for all logic (FIFO read clocks and FT write side)
- reset_n  in  1  synchronous, active-low reset
- enable_i  in  1  1 = new packets may start
- iq_data_i  in  IQ_PAIR_WIDTH  IQ FIFO Q; valid the cycle after iq_re_o
- iq_enough_i  in  1  IQ FIFO holds >= PKT_WORDS
- iq_re_o  out  1  IQ FIFO read enable
- cpu_data_i  in  FT_DATA_WIDTH  CPU FIFO Q; valid the cycle after cpu_re_o
- cpu_level_i  in  LVL_W  CPU FIFO word count (0 = empty)
- cpu_re_o  out  1  CPU FIFO read enable
- data_o  out  FT_DATA_WIDTH  stream data
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts when valid_o && ready_i
- busy_o  out  1  packet in progress
- src_o  out  2  source of current packet: 0 none, 1 IQ, 2 CPU
- seq_o  out  16  sequence number of the next packet

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - All outputs 0: iq_re_o, cpu_re_o, valid_o, busy_o, src_o, seq_o, data_o.
  - Output buffer emptied; last-grant pointer set to CPU, so IQ wins the first tie.
  - Reset mid-packet aborts immediately; no completion.
- States: IDLE, HDR, PAYLOAD.
- IDLE (busy_o = 0):
  - Request IQ = iq_enough_i; request CPU = cpu_level_i != 0; both gated by enable_i.
  - Both requesting: grant the source not granted last. One requesting: grant it.
  - On grant, latch length into words_left:
    - IQ: PKT_WORDS.
    - CPU: min(cpu_level_i, CPU_BURST), sampled in the grant cycle.
  - Go to HDR.
- HDR:
  - Push header into the output buffer: [31:28] = 4'hA, [27:24] = src (1 IQ, 2 CPU), [23:16] = length, [15:0] = seq.
  - seq increments on header push, wrapping 0xFFFF to 0.
  - header valid_o appears one cycle after the grant.
  - Go to PAYLOAD.
- PAYLOAD:
  - Assert the granted FIFO's re while words_left > 0 and buffer space allows, counting in-flight reads.
  - Decrement words_left per re.
  - Returning data is pushed the following cycle.
  - IQ word mapping: I to [11:0]; Q to [QSTART_BIT_INDEX+11:QSTART_BIT_INDEX]; all other bits 0.
  - CPU words pass through unchanged.
  - When words_left = 0 and no read is in flight, go to IDLE and update the last-grant pointer.
- Output buffer: 2-entry FIFO (skid buffer).
  - valid_o = buffer non-empty; data_o = head entry.
  - Head is held stable while valid_o && !ready_i.
  - re is issued only if free entries > reads in flight, so the buffer never overflows.
  - With ready_i held at 1: one payload word per cycle, no bubbles. Packet of N words = N+1 consecutive valid beats.
- Boundaries:
  - enable_i falling mid-packet: the packet completes in full, then the block stays in IDLE.
  - CPU length is fixed at grant; words arriving later wait for the next packet.
  - ready_i = 0 indefinitely: block stalls, no FIFO reads, no data lost.
  - re is never asserted for a source outside its own packet.

Decomposition:
- Shared package ft_pkt_pkg:
  - Sync nibble 4'hA.
  - Source codes: SRC_NONE = 0, SRC_IQ = 1, SRC_CPU = 2.
  - Header field bit positions.
  - State encoding.
- One sub-module, ft_skid_buf: 2-entry valid/ready buffer with a free-count output used for read gating.

Test Plan:
1. Reset with PKT_WORDS = 4; hold iq_enough_i = 1, ready_i = 1; I = 0x123, Q = 0x456 → next 4 beats are 0x04560123 each; seq_o becomes 1.
   - First beat after reset: header 0xA1040000.
2. cpu_level_i = 3, words 0xDEADBEEF, 0x1, 0x2, IQ idle → 4 beats: header 0xA2030000, then 0xDEADBEEF, 0x1, 0x2.
   - cpu_re_o asserted exactly 3 cycles.
3. cpu_level_i = 20, CPU_BURST = 8 → header length field 8; exactly 8 reads; a second CPU packet follows, length 8 if level is still >= 8.
4. IQ and CPU both requesting continuously → packets alternate IQ, CPU, IQ, CPU; src_o matches each header.
5. ready_i toggled with a random pattern during an IQ packet → data_o stable while stalled; all 4 payload words arrive in order with no duplicates or loss.
6. Preload seq to 0xFFFF → next header seq 0xFFFF, following header 0x0000.
   - Also: deassert enable_i after the header; the packet completes and no new header appears.
   - Also: reset_n low mid-payload; all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ft_pkt_pkg.sv
// Shared definitions for the FT600 write-stream packet framing.
// Holds the header layout, source codes and scheduler state encoding.
package ft_pkt_pkg;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam int HDR_SYNC_LSB = 28;
    localparam int HDR_SRC_LSB  = 24;
    localparam int HDR_LEN_LSB  = 16;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IQ   = 2'd1,
        SRC_CPU  = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    function automatic logic [31:0] make_header(input src_e src, input logic [7:0] len,
                                                input logic [15:0] seq);
        logic [31:0] hdr;
        hdr = 32'h0000_0000;
        hdr[HDR_SYNC_LSB +: 4] = SYNC_NIBBLE;
        hdr[HDR_SRC_LSB +: 4]  = {2'b00, src};
        hdr[HDR_LEN_LSB +: 8]  = len;
        hdr[HDR_SEQ_LSB +: 16] = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/ft_skid_buf.sv
// Two-entry valid/ready output buffer; free_cnt already credits a pop happening
// this cycle so the producer can keep one word per cycle flowing.
module ft_skid_buf
    import ft_pkt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       free_cnt
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic             pop_s;

    assign pop_s      = (count_r != 2'd0) && pop_ready;
    assign head_valid = (count_r != 2'd0);
    assign head_data  = head_r;
    assign free_cnt   = 2'd2 - count_r + {1'b0, pop_s};

    // Buffer storage and occupancy update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r  <= push_data;
                        count_r <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_r  <= push_data;
                        count_r <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/ft_tx_scheduler.sv
// Round-robin packet scheduler merging the IQ sample FIFO and the CPU reply FIFO
// into framed packets (header + payload) toward the FT600 write path.
module ft_tx_scheduler
    import ft_pkt_pkg::*;
#(
    parameter int          FT_DATA_WIDTH    = 32,
    parameter int          IQ_PAIR_WIDTH    = 24,
    parameter int          QSTART_BIT_INDEX = 16,
    parameter int          PKT_WORDS        = 32,
    parameter int          CPU_BURST        = 8,
    parameter int          LVL_W            = 8,
    parameter logic [15:0] SEQ_RESET_VAL    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable_i,
    input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
    input  logic                     iq_enough_i,
    output logic                     iq_re_o,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic [LVL_W-1:0]         cpu_level_i,
    output logic                     cpu_re_o,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o,
    output logic [1:0]               src_o,
    output logic [15:0]              seq_o
);

    localparam logic [7:0] PKT_LEN = 8'(PKT_WORDS);

    state_e      state_r, state_s;
    src_e        src_r, src_s;
    logic        last_cpu_r, last_cpu_s;
    logic [7:0]  words_left_r, words_left_s;
    logic [15:0] seq_r, seq_s;
    logic        inflight_r;
    logic        re_s, hdr_push_s, buf_push_s;
    logic        req_iq_s, req_cpu_s;
    logic [7:0]  cpu_len_s;
    logic [1:0]  free_s;
    logic [FT_DATA_WIDTH-1:0] iq_word_s, push_data_s;

    // Request qualification, CPU burst clamp and IQ payload packing
    always_comb begin
        req_iq_s  = enable_i && iq_enough_i;
        req_cpu_s = enable_i && (cpu_level_i != {LVL_W{1'b0}});
        if (cpu_level_i > LVL_W'(CPU_BURST)) begin
            cpu_len_s = 8'(CPU_BURST);
        end else begin
            cpu_len_s = 8'(cpu_level_i);
        end
        iq_word_s = {FT_DATA_WIDTH{1'b0}};
        iq_word_s[11:0] = iq_data_i[11:0];
        iq_word_s[QSTART_BIT_INDEX +: 12] = iq_data_i[23:12];
    end

    // Next-state, grant and read-enable logic
    always_comb begin
        state_s      = state_r;
        src_s        = src_r;
        last_cpu_s   = last_cpu_r;
        words_left_s = words_left_r;
        seq_s        = seq_r;
        hdr_push_s   = 1'b0;
        re_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_iq_s && (!req_cpu_s || last_cpu_r)) begin
                    src_s        = SRC_IQ;
                    words_left_s = PKT_LEN;
                    state_s      = ST_HDR;
                end else if (req_cpu_s) begin
                    src_s        = SRC_CPU;
                    words_left_s = cpu_len_s;
                    state_s      = ST_HDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                // The first read may launch alongside the header if both fit.
                if (free_s != 2'd0) begin
                    hdr_push_s = 1'b1;
                    seq_s      = seq_r + 16'd1;
                    re_s       = (words_left_r != 8'd0) && (free_s > 2'd1);
                    state_s    = ST_PAYLOAD;
                end else begin
                    state_s = ST_HDR;
                end
                if (re_s) begin
                    words_left_s = words_left_r - 8'd1;
                end else begin
                    words_left_s = words_left_r;
                end
            end
            ST_PAYLOAD: begin
                re_s = (words_left_r != 8'd0) && (free_s > {1'b0, inflight_r});
                if (re_s) begin
                    words_left_s = words_left_r - 8'd1;
                end else begin
                    words_left_s = words_left_r;
                end
                if ((words_left_r == 8'd0) && !inflight_r) begin
                    last_cpu_s = (src_r == SRC_CPU);
                    src_s      = SRC_NONE;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            default: begin
                src_s   = SRC_NONE;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Buffer write selection: header from HDR, otherwise returning FIFO data
    always_comb begin
        buf_push_s = hdr_push_s || inflight_r;
        if (hdr_push_s) begin
            push_data_s = make_header(src_r, words_left_r, seq_r);
        end else if (src_r == SRC_IQ) begin
            push_data_s = iq_word_s;
        end else begin
            push_data_s = cpu_data_i;
        end
    end

    // Scheduler state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            src_r        <= SRC_NONE;
            last_cpu_r   <= 1'b1;
            words_left_r <= 8'd0;
            seq_r        <= SEQ_RESET_VAL;
            inflight_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            src_r        <= src_s;
            last_cpu_r   <= last_cpu_s;
            words_left_r <= words_left_s;
            seq_r        <= seq_s;
            inflight_r   <= re_s;
        end
    end

    assign iq_re_o  = re_s && (src_r == SRC_IQ);
    assign cpu_re_o = re_s && (src_r == SRC_CPU);
    assign busy_o   = (state_r != ST_IDLE);
    assign src_o    = src_r;
    assign seq_o    = seq_r;

    ft_skid_buf #(.WIDTH(FT_DATA_WIDTH)) u_skid_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (buf_push_s),
        .push_data  (push_data_s),
        .pop_ready  (ready_i),
        .head_data  (data_o),
        .head_valid (valid_o),
        .free_cnt   (free_s)
    );

endmodule

// File: tb/tb_ft_tx_scheduler.sv
// Directed self-checking bench for ft_tx_scheduler with FIFO models and a beat monitor.
// A second instance starts its sequence counter at 0xFFFF to exercise wrap-around.
module tb_ft_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        iq_enough_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [23:0] iq_data_i = 24'h456123;
    logic [31:0] cpu_data_i = 32'h0;
    logic [7:0]  cpu_level_i = 8'h0;

    logic        iq_re_o, cpu_re_o, valid_o, busy_o;
    logic [31:0] data_o;
    logic [1:0]  src_o;
    logic [15:0] seq_o;
    logic        w_iq_re_o, w_cpu_re_o, w_valid_o, w_busy_o;
    logic [31:0] w_data_o;
    logic [1:0]  w_src_o;
    logic [15:0] w_seq_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          iq_rd = 0;
    int          cpu_rd = 0;
    logic [31:0] beats[$];
    logic [31:0] w_beats[$];
    int          bcyc[$];
    logic [1:0]  bsrc[$];
    logic [31:0] cpu_q[$];
    logic        iq_inc = 1'b0;
    logic [11:0] iq_ctr = 12'h0;
    logic        hold_chk = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;

    ft_tx_scheduler #(.PKT_WORDS(4), .CPU_BURST(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .iq_data_i(iq_data_i),
        .iq_enough_i(iq_enough_i), .iq_re_o(iq_re_o), .cpu_data_i(cpu_data_i),
        .cpu_level_i(cpu_level_i), .cpu_re_o(cpu_re_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .src_o(src_o), .seq_o(seq_o)
    );

    ft_tx_scheduler #(.PKT_WORDS(4), .CPU_BURST(8), .SEQ_RESET_VAL(16'hFFFF)) dut_w (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .iq_data_i(iq_data_i),
        .iq_enough_i(iq_enough_i), .iq_re_o(w_iq_re_o), .cpu_data_i(cpu_data_i),
        .cpu_level_i(cpu_level_i), .cpu_re_o(w_cpu_re_o), .data_o(w_data_o),
        .valid_o(w_valid_o), .ready_i(ready_i), .busy_o(w_busy_o), .src_o(w_src_o),
        .seq_o(w_seq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        beats.delete();
        w_beats.delete();
        bcyc.delete();
        bsrc.delete();
        iq_rd = 0;
        cpu_rd = 0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("beat_count", beats.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle_reached", {31'b0, busy_o}, 32'd0);
    endtask

    function automatic logic [31:0] hdr_hi(input int i);
        logic [31:0] w;
        w = beats[i];
        return {16'h0, w[31:16]};
    endfunction

    // IQ FIFO model: data follows the read enable by one cycle
    always @(posedge clk) begin
        if (iq_re_o) begin
            iq_data_i <= iq_inc ? {12'h200 + iq_ctr, 12'h100 + iq_ctr} : 24'h456123;
            iq_ctr    <= iq_ctr + 12'd1;
        end
    end

    // CPU FIFO model: pop on read enable
    always @(posedge clk) begin
        if (cpu_re_o && cpu_q.size() != 0) cpu_data_i <= cpu_q.pop_front();
    end

    // Beat monitor, stall-hold checker and CPU level update, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (hold_chk && prev_stall) begin
            check_eq("hold_data", data_o, prev_data);
            check_eq("hold_valid", {31'b0, valid_o}, 32'd1);
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        if (reset_n && valid_o && ready_i) begin
            beats.push_back(data_o);
            bcyc.push_back(cyc);
            bsrc.push_back(src_o);
        end
        if (reset_n && w_valid_o && ready_i) w_beats.push_back(w_data_o);
        if (reset_n && iq_re_o) iq_rd++;
        if (reset_n && cpu_re_o) cpu_rd++;
        cpu_level_i = 8'(cpu_q.size());
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        logic [11:0] base;
        logic [11:0] v;
        // Reset state
        tick(3);
        check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
        check_eq("rst_busy", {31'b0, busy_o}, 32'd0);
        check_eq("rst_src", {30'b0, src_o}, 32'd0);
        check_eq("rst_seq", {16'b0, seq_o}, 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_re", {30'b0, iq_re_o, cpu_re_o}, 32'd0);

        // IQ packet, constant sample, back-to-back beats
        reset_n = 1'b1; enable_i = 1'b1; iq_enough_i = 1'b1; ready_i = 1'b1;
        tick();
        iq_enough_i = 1'b0;
        wait_beats(5, 30);
        wait_idle(20);
        check_eq("iq_hdr", beats[0], 32'hA1040000);
        for (int i = 1; i < 5; i++) check_eq("iq_payload", beats[i], 32'h04560123);
        check_eq("iq_src", {30'b0, bsrc[0]}, 32'd1);
        check_eq("iq_no_bubble", bcyc[4] - bcyc[0], 32'd4);
        check_eq("iq_seq_after", {16'b0, seq_o}, 32'd1);
        check_eq("wrap_hdr_ffff", w_beats[0], 32'hA104FFFF);
        check_eq("wrap_seq_after", {16'b0, w_seq_o}, 32'd0);

        // Short CPU packet
        clr();
        cpu_q.push_back(32'hDEADBEEF); cpu_q.push_back(32'h1); cpu_q.push_back(32'h2);
        wait_beats(4, 30);
        wait_idle(20);
        check_eq("cpu_hdr", beats[0], 32'hA2030001);
        check_eq("cpu_w0", beats[1], 32'hDEADBEEF);
        check_eq("cpu_w1", beats[2], 32'h1);
        check_eq("cpu_w2", beats[3], 32'h2);
        check_eq("cpu_src", {30'b0, bsrc[0]}, 32'd2);
        check_eq("cpu_reads", cpu_rd, 32'd3);
        check_eq("wrap_hdr_0000", w_beats[0], 32'hA2030000);

        // CPU burst clamp: 20 words -> 8, 8, 4
        clr();
        for (int i = 0; i < 20; i++) cpu_q.push_back(32'h100 + 32'(i));
        wait_beats(23, 120);
        wait_idle(20);
        check_eq("burst_hdr0", beats[0], 32'hA2080002);
        check_eq("burst_hdr1", beats[9], 32'hA2080003);
        check_eq("burst_hdr2", beats[18], 32'hA2040004);
        check_eq("burst_first", beats[1], 32'h100);
        check_eq("burst_p0_last", beats[8], 32'h107);
        check_eq("burst_p1_last", beats[17], 32'h10F);
        check_eq("burst_last", beats[22], 32'h113);
        check_eq("burst_reads", cpu_rd, 32'd20);

        // Both sources requesting: alternate IQ, CPU, IQ, CPU
        clr();
        for (int i = 0; i < 16; i++) cpu_q.push_back(32'h200 + 32'(i));
        iq_enough_i = 1'b1;
        wait_beats(28, 200);
        enable_i = 1'b0; iq_enough_i = 1'b0;
        tick();
        wait_idle(40);
        check_eq("rr_hdr0", hdr_hi(0), 32'h0000A104);
        check_eq("rr_hdr1", hdr_hi(5), 32'h0000A208);
        check_eq("rr_hdr2", hdr_hi(14), 32'h0000A104);
        check_eq("rr_hdr3", hdr_hi(19), 32'h0000A208);
        check_eq("rr_src0", {30'b0, bsrc[0]}, 32'd1);
        check_eq("rr_src1", {30'b0, bsrc[5]}, 32'd2);
        check_eq("rr_src3", {30'b0, bsrc[19]}, 32'd2);
        check_eq("rr_cpu_w0", beats[6], 32'h200);
        cpu_q.delete();

        // Random-ish backpressure on an IQ packet; enable drops after the header
        clr();
        tick(2);
        base = iq_ctr;
        iq_inc = 1'b1; hold_chk = 1'b1;
        enable_i = 1'b1; iq_enough_i = 1'b1;
        pat = 16'b1011_0010_0110_1001;
        for (int c = 0; c < 80; c++) begin
            ready_i = pat[c % 16];
            if (beats.size() >= 1) enable_i = 1'b0;
            tick();
        end
        ready_i = 1'b1;
        tick(10);
        hold_chk = 1'b0; iq_enough_i = 1'b0;
        check_eq("bp_beats", beats.size(), 32'd5);
        check_eq("bp_hdr", hdr_hi(0), 32'h0000A104);
        for (int k = 1; k < 5; k++) begin
            v = base + 12'(k - 1);
            check_eq("bp_payload", beats[k], {4'h0, 12'h200 + v, 4'h0, 12'h100 + v});
        end
        check_eq("bp_reads", iq_rd, 32'd4);
        check_eq("bp_idle", {31'b0, busy_o}, 32'd0);

        // ready_i held low: header plus one word buffered, nothing else read
        clr();
        enable_i = 1'b1; ready_i = 1'b0;
        for (int i = 0; i < 5; i++) cpu_q.push_back(32'h300 + 32'(i));
        tick(20);
        check_eq("stall_reads", cpu_rd, 32'd1);
        check_eq("stall_valid", {31'b0, valid_o}, 32'd1);
        check_eq("stall_hdr", {16'h0, data_o[31:16]}, 32'h0000A205);
        ready_i = 1'b1;
        wait_beats(6, 40);
        wait_idle(20);
        check_eq("stall_w0", beats[1], 32'h300);
        check_eq("stall_w4", beats[5], 32'h304);
        check_eq("stall_reads_total", cpu_rd, 32'd5);

        // Reset in the middle of a payload
        clr();
        for (int i = 0; i < 8; i++) cpu_q.push_back(32'h400 + 32'(i));
        wait_beats(3, 30);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        check_eq("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check_eq("mid_rst_src", {30'b0, src_o}, 32'd0);
        check_eq("mid_rst_seq", {16'b0, seq_o}, 32'd0);
        check_eq("mid_rst_data", data_o, 32'd0);
        check_eq("mid_rst_re", {30'b0, iq_re_o, cpu_re_o}, 32'd0);
        check_eq("mid_rst_w", {26'b0, w_valid_o, w_busy_o, w_src_o, w_iq_re_o, w_cpu_re_o},
                 32'd0);
        check_eq("mid_rst_w_seq", {16'b0, w_seq_o}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
